// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: RV32I load/store funct3
// codes, FSM state encoding and access-classification helpers.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef logic [1:0] dmem_state_t;
    localparam dmem_state_t ST_IDLE = 2'd0;
    localparam dmem_state_t ST_WAIT = 2'd1;
    localparam dmem_state_t ST_RESP = 2'd2;

    // funct3 codes with no defined meaning for this access direction
    function automatic logic f3_undef(input logic we, input logic [2:0] f3);
        case (f3)
            3'b011, 3'b110, 3'b111: f3_undef = 1'b1;
            3'b100, 3'b101:         f3_undef = we;
            default:                f3_undef = 1'b0;
        endcase
    endfunction

    // half accesses need addr[0]=0, word accesses need addr[1:0]=0
    function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LH, F3_LHU: f3_misalign = off[0];
            F3_LW:         f3_misalign = |off;
            default:       f3_misalign = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core load/store port bundle. The core drives the master side, the
// memory responder sits on the slave side.
interface data_mem_responder_if;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_err
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering between the 32-bit array word and the core.
// Load side extracts and extends a byte/half/word; store side produces
// byte enables and lane-replicated store data. Offsets that are not
// naturally aligned are force-aligned here (addr[0] dropped for halves,
// addr[1:0] dropped for words); fault handling lives in the top level.
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // load extraction and sign/zero extension
    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_o = {24'd0, byte_sel};
            F3_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_o = {16'd0, half_sel};
            F3_LW:   load_o = word_i;
            default: load_o = 32'd0;
        endcase
    end

    // store byte enables with data replicated into every candidate lane
    always_comb begin
        be_o      = 4'b0000;
        st_data_o = 32'd0;
        case (funct3_i)
            F3_SB: begin
                be_o      = 4'b0001 << off_i;
                st_data_o = {4{wdata_i[7:0]}};
            end
            F3_SH: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{wdata_i[15:0]}};
            end
            F3_SW: begin
                be_o      = 4'b1111;
                st_data_o = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data memory behind the core load/store port.
// IDLE captures a request, WAIT burns WAIT_STATES cycles, RESP performs the
// access; the registered response (ready/err/rdata) appears the cycle after
// RESP, i.e. WAIT_STATES+1 cycles after the capturing edge.
// Build option DMEM_ERR_EN: misaligned, out-of-range and undefined accesses
// raise mem_err and are suppressed. Without it mem_err is 0, misaligned
// accesses are force-aligned and addresses wrap modulo DEPTH.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_responder_if.slave bus
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, err_q;
    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   ld_val, st_data;
    logic [3:0]    be;
    logic          undef, mis, range_err, fault, err_d, commit;

    assign idx = addr_q[AW+1:2];

    dmem_lane_align u_align (
        .word_i    (mem_q[idx]),
        .off_i     (addr_q[1:0]),
        .funct3_i  (f3_q),
        .wdata_i   (wdata_q),
        .load_o    (ld_val),
        .be_o      (be),
        .st_data_o (st_data)
    );

    // access classification on the latched request
    always_comb begin
        undef     = f3_undef(we_q, f3_q);
        mis       = f3_misalign(f3_q, addr_q[1:0]);
        range_err = (addr_q >= LIMIT);
`ifdef DMEM_ERR_EN
        fault     = undef | mis | range_err;
        err_d     = (state_q == ST_RESP) && fault;
`else
        fault     = undef;
        err_d     = 1'b0;
`endif
        commit    = (state_q == ST_RESP) && we_q && !fault;
        rdata_d   = ((state_q == ST_RESP) && !we_q && !fault) ? ld_val : 32'd0;
    end

`ifndef DMEM_ERR_EN
    // alignment and range are deliberately ignored in this build
    logic unused_fault_bits;
    assign unused_fault_bits = mis ^ range_err;
`endif

    // FSM next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (bus.mem_req) begin
                cnt_d   = WS;
                state_d = (WS != 4'd0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state, request latch and registered response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && bus.mem_req) begin
                we_q    <= bus.mem_we;
                f3_q    <= bus.mem_funct3;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
            end
            ready_q <= (state_q == ST_RESP);
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // array write on the edge leaving RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
`ifdef DMEM_ERR_EN
    assign bus.mem_err   = err_q;
`else
    assign bus.mem_err   = 1'b0;
    logic unused_err_q;
    assign unused_err_q  = err_q;
`endif

endmodule
